// File: rtl/ooo_responder_pkg.sv
// Shared types for the out-of-order AXI read responder: slot record, FSM states,
// LFSR feedback taps and the AXI response codes the responder emits.
package ooo_responder_pkg;

    localparam int SLOT_ID_W   = 32;
    localparam int SLOT_ADDR_W = 32;
    localparam int SLOT_LEN_W  = 8;
    localparam int SLOT_SIZE_W = 3;

    typedef struct packed {
        logic                   valid;
        logic [SLOT_ID_W-1:0]   id;
        logic [SLOT_ADDR_W-1:0] addr;
        logic [SLOT_LEN_W-1:0]  len;
        logic [SLOT_SIZE_W-1:0] size;
        logic [SLOT_LEN_W-1:0]  beat;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        BURST  = 2'd2
    } fsm_e;

    // Fibonacci taps 8,6,5,4 expressed as a mask over state bits [7:0]
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ooo_responder_if.sv
// AXI read-address and read-data channel bundles used between the ROB and the
// downstream responder.
interface ar_if #(
    parameter int ID_WIDTH   = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int SIZE_WIDTH = 3
) ();
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [SIZE_WIDTH-1:0] size;
    logic [1:0]            burst;
    logic [3:0]            qos;

    modport sender   (output valid, id, addr, len, size, burst, qos, input ready);
    modport receiver (input valid, id, addr, len, size, burst, qos, output ready);
endinterface

interface r_if #(
    parameter int ID_WIDTH   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2
) ();
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;

    modport sender   (output valid, id, data, resp, last, input ready);
    modport receiver (input valid, id, data, resp, last, output ready);
endinterface

// File: rtl/ooo_read_responder_lfsr8.sv
// 8-bit Fibonacci LFSR used to rotate the responder's slot-selection start point.
module lfsr8
    import ooo_responder_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic [7:0] state_o
);

    logic [7:0] state_q;
    logic [7:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en_i) begin
            state_d = {state_q[6:0], ^(state_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/ooo_read_responder.sv
// AXI read slave that buffers up to DEPTH bursts and answers them in LFSR-rotated
// order; each beat's data is its own address so reordering is visible end to end.
module ooo_read_responder
    import ooo_responder_pkg::*;
#(
    parameter int         ID_WIDTH   = SLOT_ID_W,
    parameter int         ADDR_WIDTH = SLOT_ADDR_W,
    parameter int         DATA_WIDTH = 64,
    parameter int         RESP_WIDTH = 2,
    parameter int         LEN_WIDTH  = SLOT_LEN_W,
    parameter int         SIZE_WIDTH = SLOT_SIZE_W,
    parameter int         DEPTH      = 4,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic   clk,
    input  logic   rst,
    ar_if.receiver ar_in,
    r_if.sender    r_out,
    input  logic   resp_en,
    output logic   busy
);

    localparam int IDX_W = $clog2(DEPTH);

    slot_t                 slot_q [DEPTH];
    slot_t                 slot_d [DEPTH];
    fsm_e                  state_q, state_d;
    logic [IDX_W-1:0]      cur_q, cur_d;
    logic                  ar_ready_q, ar_ready_d;
    logic                  r_valid_q, r_valid_d;
    logic                  r_last_q, r_last_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [RESP_WIDTH-1:0] r_resp_q, r_resp_d;

    logic [DEPTH-1:0]      vld;
    logic [DEPTH-1:0]      vld_next;
    logic [IDX_W-1:0]      sel;
    logic [IDX_W-1:0]      free_idx;
    logic [LEN_WIDTH-1:0]  nb;
    logic                  accept;
    logic                  hs;
    logic [7:0]            lfsr;
    logic                  unused_ok;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .en_i    (1'b1),
        .state_o (lfsr)
    );

    // First valid slot at or after start, wrapping around the table
    function automatic logic [IDX_W-1:0] pick_slot(input logic [DEPTH-1:0] v,
                                                   input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] idx;
        pick_slot = start;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = start + IDX_W'(k);
            if (v[idx]) pick_slot = idx;
        end
    endfunction

    function automatic logic [IDX_W-1:0] lowest_free(input logic [DEPTH-1:0] v);
        lowest_free = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (!v[k]) lowest_free = IDX_W'(k);
        end
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [SIZE_WIDTH-1:0] size,
                                                        input logic [LEN_WIDTH-1:0]  beat);
        beat_addr = base + (ADDR_WIDTH'(beat) << size);
    endfunction

    function automatic logic [RESP_WIDTH-1:0] beat_resp(input logic [ADDR_WIDTH-1:0] base);
        beat_resp = base[ADDR_WIDTH-1] ? RESP_WIDTH'(RESP_SLVERR) : RESP_WIDTH'(RESP_OKAY);
    endfunction

    always_comb begin
        vld = '0;
        for (int k = 0; k < DEPTH; k++) vld[k] = slot_q[k].valid;
    end

    assign accept = ar_in.valid & ar_ready_q;
    assign hs     = r_valid_q & r_out.ready;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) slot_d[k] = slot_q[k];
        state_d   = state_q;
        cur_d     = cur_q;
        r_valid_d = r_valid_q;
        r_last_d  = r_last_q;
        r_id_d    = r_id_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        sel       = pick_slot(vld, lfsr[IDX_W-1:0]);
        free_idx  = lowest_free(vld);
        nb        = slot_q[cur_q].beat + LEN_WIDTH'(1);

        // The accept only ever lands in a slot that is free now, so it never collides
        // with the slot being served or cleared below.
        if (accept) begin
            slot_d[free_idx] = '{valid: 1'b1, id: ar_in.id, addr: ar_in.addr,
                                 len: ar_in.len, size: ar_in.size, beat: '0};
        end

        case (state_q)
            IDLE: begin
                if (resp_en && (|vld)) state_d = SELECT;
            end
            SELECT: begin
                cur_d     = sel;
                r_valid_d = 1'b1;
                r_id_d    = slot_q[sel].id;
                r_data_d  = DATA_WIDTH'(beat_addr(slot_q[sel].addr, slot_q[sel].size,
                                                  slot_q[sel].beat));
                r_resp_d  = beat_resp(slot_q[sel].addr);
                r_last_d  = (slot_q[sel].beat == slot_q[sel].len);
                state_d   = BURST;
            end
            BURST: begin
                if (hs) begin
                    if (r_last_q) begin
                        slot_d[cur_q].valid = 1'b0;
                        r_valid_d           = 1'b0;
                        r_last_d            = 1'b0;
                        state_d             = IDLE;
                    end else begin
                        slot_d[cur_q].beat = nb;
                        r_data_d = DATA_WIDTH'(beat_addr(slot_q[cur_q].addr,
                                                          slot_q[cur_q].size, nb));
                        r_last_d = (nb == slot_q[cur_q].len);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        vld_next = '0;
        for (int k = 0; k < DEPTH; k++) vld_next[k] = slot_d[k].valid;
        ar_ready_d = ~(&vld_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
            state_q    <= IDLE;
            cur_q      <= '0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_id_q     <= '0;
            r_data_q   <= '0;
            r_resp_q   <= '0;
        end else begin
            slot_q     <= slot_d;
            state_q    <= state_d;
            cur_q      <= cur_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_id_q     <= r_id_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    assign ar_in.ready = ar_ready_q;
    assign r_out.valid = r_valid_q;
    assign r_out.last  = r_last_q;
    assign r_out.id    = r_id_q;
    assign r_out.data  = r_data_q;
    assign r_out.resp  = r_resp_q;
    assign busy        = (|vld) | (state_q != IDLE);

    // burst/qos are accepted but INCR is always applied; only the low LFSR bits pick
    assign unused_ok = &{1'b0, ar_in.burst, ar_in.qos, lfsr[7:IDX_W]};

endmodule

// File: doc/ooo_read_responder.md
Name: ooo_read_responder

Overview:
Downstream AXI read-slave stage that consumes the ROB's outgoing AR stream and produces the R stream that feeds the ROB's incoming response buffer.
- Holds up to DEPTH outstanding read bursts.
- Picks which burst to serve next through a pseudo-random rotating pointer, so responses return out of order across IDs (UIDs).
- Returns deterministic data: each beat's data is that beat's address. This lets benches check the ROB's reordering end to end.

Parameters:
ID_WIDTH, 32, width of AR/R ID (carries ROB UID)
ADDR_WIDTH, 32, AR address width
DATA_WIDTH, 64, R data width
RESP_WIDTH, 2, R resp width
LEN_WIDTH, 8, AR len width
SIZE_WIDTH, 3, AR size width
DEPTH, 4, outstanding burst slots (power of 2, >=2)
LFSR_SEED, 8'hA5, LFSR reset value (must be non-zero)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ar_in  ar_if.receiver  -  AR requests (id, addr, len, size, burst, qos, valid/ready)
r_out  r_if.sender  -  R beats (id, data, resp, last, valid/ready)
resp_en  in  1  1 = allowed to start new bursts; 0 = hold off new selections
busy  out  1  any slot valid or burst in flight

Behaviour:
- One clock; reset is synchronous and active-high. Reset state: all slots invalid, ar_in.ready=0, r_out.valid=0, r_out.last=0, r_out.id/data/resp=0, busy=0, lfsr=LFSR_SEED, FSM=IDLE.
- Slot table, per entry: valid, id, addr, len, size, beat (LEN_WIDTH).
- ar_in.ready is registered: 1 iff at least one slot is free after this cycle's accept and free. It is therefore 0 in the cycle after reset and deasserts the cycle after the last free slot fills.
- AR accept (valid & ready) writes the lowest-index free slot, which becomes valid the next cycle. burst and qos are ignored; INCR semantics are applied.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every cycle outside reset.
- FSM IDLE -> SELECT -> BURST -> IDLE.
  - IDLE: if resp_en and any slot valid, go to SELECT.
  - SELECT (1 cycle): start = lfsr[$clog2(DEPTH)-1:0]; choose the first valid slot at index >= start, wrapping modulo DEPTH. Latch it as cur, then go to BURST.
  - BURST: r_out.valid=1. id = slot id. data = zero-extend(addr + beat*(1<<size)), with the sum computed in ADDR_WIDTH bits and wrapping mod 2^ADDR_WIDTH. resp = 2'b10 (SLVERR) if addr[ADDR_WIDTH-1]=1, else 2'b00. last = (beat==len).
  - On each handshake, beat++. On a handshake with last=1, clear the slot and go to IDLE.
- Latency: AR accept to first R valid is at least 3 cycles (slot write, IDLE->SELECT, SELECT->BURST). There is one bubble cycle between bursts.
- Backpressure: while r_out.valid && !r_out.ready, all R fields hold stable.
- Bursts are never interleaved; a started burst always completes regardless of resp_en.
- Simultaneous AR accept and slot free in the same cycle: the accept targets a slot free at the start of the cycle, so there is no conflict. The freed slot counts toward the next cycle's ready.
- len=0: single beat with last=1.
- len=255 (max) is supported; beat must not overflow before last.
- Reset mid-burst: all state is dropped; r_out.valid=0 on the next cycle and no partial beats are sent.
- busy = |slot.valid | (FSM!=IDLE).

Decomposition:
- Package ooo_responder_pkg: slot_t struct (parameterised widths passed as localparams), fsm_e enum {IDLE, SELECT, BURST}, LFSR_TAPS constant, RESP_OKAY/RESP_SLVERR constants.
- One sub-module: lfsr8 (seed param, en, state out).
- Slot search is an inline function.

Test Plan:
1. Reset, then one AR with id=5, addr=0x100, len=3, size=3 -> 4 beats, data 0x100, 0x108, 0x110, 0x118, id=5, resp=0, last only on beat 4. First valid arrives 3 cycles after accept.
2. Fill 4 slots (ids 1..4, len=0) with no gaps -> ar_in.ready drops after the 4th accept and rises 1 cycle after the first burst completes. All 4 ids are returned exactly once, in an order differing from 1,2,3,4 for seed 8'hA5.
3. Backpressure: len=2, r_out.ready toggled 1/0 each cycle -> data/id/last hold stable while not ready, and exactly 3 handshakes occur.
4. resp_en=0 with 2 slots loaded -> r_out.valid stays 0 for 20 cycles. Setting resp_en=1 starts the first burst within 2 cycles. Dropping resp_en mid-burst still lets that burst finish.
5. addr=0xFFFF_FFF8, len=1, size=3 -> data 0xFFFF_FFF8 then 0x0000_0000 (wrap), and resp=2'b10 on both beats.
6. Assert rst during beat 2 of a len=7 burst -> next cycle r_out.valid=0, busy=0, ar_in.ready=0. After reset the first burst is re-served only if it is re-issued.
